seven_seg_scanner: RTL
======================

Name: seven_seg_scanner

Overview:
Consumes the 16-bit `indicator` word produced by the data output port stage and drives a 4-digit, time-multiplexed, common-anode 7-segment display. It rotates through the four hex nibbles, decoding each to segment patterns. Between digits it inserts a dead-time blanking interval to suppress ghosting. At each frame boundary it snapshots `indicator`, so a half-updated word is never shown.

Parameters:
CLK_DIV, 1000, clock cycles per digit slot; legal range 2..65535.
DEAD_CYCLES, 16, blanked cycles at the start of each slot; must satisfy 1 <= DEAD_CYCLES < CLK_DIV.
ACTIVE_LOW, 1, 1 = segments, dp and anodes are active-low; 0 = all active-high.

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
indicator  input  16  four hex digits; [3:0] = digit 0 (rightmost) ... [15:12] = digit 3
enable  input  1  1 = scan running; 0 = display dark, scan frozen
dp_mask  input  4  bit n lights the decimal point of digit n
segments  output  7  bit0 = a ... bit6 = g
dp  output  1  decimal point of the active digit
anodes  output  4  bit n selects digit n
frame_done  output  1  one-cycle pulse when a new frame starts

Behaviour:
- Reset and clock: reset is synchronous, active-high; the clock is `clock`.
- Reset state:
  - prescaler `cnt` = 0, digit index `idx` = 0, shadow = 16'h0000, frame_done = 0.
  - segments, dp and anodes are all in the OFF level: all 1s if ACTIVE_LOW = 1, all 0s otherwise.
  - Reset asserted mid-scan returns everything to these values on the next edge.
- Prescaler:
  - When enable = 1, `cnt` counts 0..CLK_DIV-1.
  - At CLK_DIV-1 it wraps to 0 and `idx` advances 0→1→2→3→0.
- Snapshot:
  - On the edge where `idx` wraps 3→0, shadow <= indicator and frame_done <= 1 for exactly one cycle.
  - The first frame after reset displays shadow = 0.
  - `indicator` changes mid-frame take effect only at the next wrap.
- Slot phases, a 2-state FSM evaluated from `cnt`:
  - BLANK while cnt < DEAD_CYCLES.
  - DRIVE while cnt >= DEAD_CYCLES.
  - BLANK: all anodes, segments and dp OFF.
  - DRIVE: anodes[idx] ON, other anodes OFF; segments = decode(shadow[4*idx+3 : 4*idx]); dp = dp_mask[idx].
  - dp_mask is sampled live, not snapshotted.
- Decode, active-high gfedcba before polarity inversion:
  - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07
  - 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71
- Output latency: all outputs are registered. Pins reflect the (cnt, idx, phase) of the previous cycle, i.e. 1 cycle of latency. No combinational path from inputs to outputs.
- Enable:
  - enable = 0: cnt and idx hold; all outputs OFF on the next edge; frame_done = 0; shadow not updated.
  - Re-enable resumes from the held cnt/idx.
- Simultaneous events:
  - reset has priority over enable.
  - A wrap and an `indicator` change in the same cycle capture the new value present on that edge.
- Ownership: exactly one anode is ever ON, and only in DRIVE.

Optional Feature:
Macro LEADING_ZERO_BLANK_EN.
- Defined: digit n (n = 3, 2, 1) shows segments OFF when shadow nibble n and all higher nibbles are zero.
  - Digit 0 is always decoded, so 16'h0000 shows a single "0".
  - The anode still follows the normal DRIVE timing, and dp still follows dp_mask.
- Not defined: every digit is always decoded; no extra logic is present.

Test Plan:
- Reset values: CLK_DIV=8, DEAD_CYCLES=2, ACTIVE_LOW=1; hold reset 3 cycles → anodes=4'hF, segments=7'h7F, dp=1, frame_done=0.
- Full frame: indicator=16'h12AF, dp_mask=0, run 32 cycles. Each 8-cycle slot shows 2 cycles dark, then 6 cycles lit:
  - digit 0: anodes=4'hE, segments=~71=7'h0E
  - digit 1: anodes=4'hD, segments=~77=7'h08
  - digit 2: anodes=4'hB, segments=~5B=7'h24
  - digit 3: anodes=4'h7, segments=~06=7'h79
  - frame_done pulses once per 32 cycles.
- Snapshot coherence: change indicator 16'h1111→16'h2222 while idx=1 → digits 2 and 3 still show "1" this frame; all digits show "2" after the next frame_done.
- Enable freeze: deassert enable for 10 cycles mid-DRIVE of digit 2 → outputs OFF within 1 cycle. After reassert, digit 2 resumes with the remaining cycle count and no extra frame_done.
- Decimal point: dp_mask=4'b0100 → dp=0 (active-low ON) only during DRIVE of digit 2; dp=1 elsewhere.
- LEADING_ZERO_BLANK_EN defined, indicator=16'h0050:
  - digits 3 and 2 have segments 7'h7F with their anodes pulsing.
  - digit 1 shows "5" (7'h12); digit 0 shows "0" (7'h40).

Source files
------------

// File: rtl/seven_seg_scanner.sv
// 4-digit time-multiplexed 7-segment scanner with per-slot dead-time blanking and a frame-coherent snapshot.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits 3..1.
module seven_seg_scanner #(
  parameter int CLK_DIV     = 1000,
  parameter int DEAD_CYCLES = 16,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] indicator,
  input  logic        enable,
  input  logic [3:0]  dp_mask,
  output logic [6:0]  segments,
  output logic        dp,
  output logic [3:0]  anodes,
  output logic        frame_done
);

  localparam logic        POL  = (ACTIVE_LOW != 0);
  localparam logic [15:0] LAST = 16'(CLK_DIV - 1);
  localparam logic [15:0] DEAD = 16'(DEAD_CYCLES);

  typedef enum logic {BLANK, DRIVE} phase_t;

  phase_t      phase_q, phase_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] shadow_q, shadow_d;
  logic [6:0]  segments_q, segments_d;
  logic        dp_q, dp_d;
  logic [3:0]  anodes_q, anodes_d;
  logic        frame_done_q, frame_done_d;

  logic        wrap;
  logic [3:0]  nib;
  logic [6:0]  seg_on;
  logic [3:0]  an_on;
  logic        dp_on;

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0: decode = 7'h3F;  4'h1: decode = 7'h06;
      4'h2: decode = 7'h5B;  4'h3: decode = 7'h4F;
      4'h4: decode = 7'h66;  4'h5: decode = 7'h6D;
      4'h6: decode = 7'h7D;  4'h7: decode = 7'h07;
      4'h8: decode = 7'h7F;  4'h9: decode = 7'h6F;
      4'hA: decode = 7'h77;  4'hB: decode = 7'h7C;
      4'hC: decode = 7'h39;  4'hD: decode = 7'h5E;
      4'hE: decode = 7'h79;  default: decode = 7'h71;
    endcase
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      phase_q      <= BLANK;
      cnt_q        <= '0;
      idx_q        <= '0;
      shadow_q     <= '0;
      segments_q   <= {7{POL}};
      dp_q         <= POL;
      anodes_q     <= {4{POL}};
      frame_done_q <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      segments_q   <= segments_d;
      dp_q         <= dp_d;
      anodes_q     <= anodes_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    phase_d      = phase_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    shadow_d     = shadow_q;
    frame_done_d = 1'b0;
    seg_on       = '0;
    an_on        = '0;
    dp_on        = 1'b0;
    wrap         = (cnt_q == LAST);
    nib          = shadow_q[{idx_q, 2'b00} +: 4];

    if (enable) begin
      cnt_d = wrap ? 16'd0 : cnt_q + 16'd1;
      if (wrap) begin
        idx_d = idx_q + 2'd1;
        // Frame boundary: latch the whole word at once so a half-updated value never shows.
        if (idx_q == 2'd3) begin
          shadow_d     = indicator;
          frame_done_d = 1'b1;
        end
      end
      // Phase tracks cnt_q, so it changes on the edge where cnt_d crosses a boundary.
      case (phase_q)
        BLANK:   if (cnt_q == DEAD - 16'd1) phase_d = DRIVE;
        default: if (wrap) phase_d = BLANK;
      endcase
      if (phase_q == DRIVE) begin
        an_on  = 4'b0001 << idx_q;
        seg_on = decode(nib);
        dp_on  = dp_mask[idx_q];
`ifdef LEADING_ZERO_BLANK_EN
        if (idx_q != 2'd0 && (shadow_q >> {idx_q, 2'b00}) == 16'h0000) seg_on = '0;
`endif
      end
    end

    segments_d = seg_on ^ {7{POL}};
    anodes_d   = an_on ^ {4{POL}};
    dp_d       = dp_on ^ POL;
  end

  assign segments   = segments_q;
  assign dp         = dp_q;
  assign anodes     = anodes_q;
  assign frame_done = frame_done_q;

endmodule
